// File: rtl/amemory_pkg.sv
// Shared sizing for the 16x1k true dual-port memory.
package amemory_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int IDX_W  = $clog2(DEPTH);
endpackage

// File: rtl/amemory_port.sv
// One memory port: address truncation to a word index and the registered read-data output.
// Latency 1 clock from read enable to DataOut; no backpressure, every enable is taken.
module amemory_port
  import amemory_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int IDX_W_P  = IDX_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W_P-1:0] address,
  input  logic                readEna,
  input  logic [DATA_W_P-1:0] rdWord,
  output logic [IDX_W_P-1:0]  index,
  output logic [DATA_W_P-1:0] dataOut
);

  // Upper address bits are ignored, so addresses wrap every DEPTH words.
  assign index = address[IDX_W_P-1:0];

  generate
    if (ADDR_W_P > IDX_W_P) begin : gHiBits
      logic unusedHiBits;
      assign unusedHiBits = ^address[ADDR_W_P-1:IDX_W_P];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= '0;
    end else if (readEna) begin
      dataOut <= rdWord;
    end
  end

endmodule

// File: rtl/amemory_16x1k.sv
// 1024x16 true dual-port memory, read-first on both ports, port 1 wins same-address writes.
// Read latency 1 clock; no handshake, synchronous reset clears outputs but never the array.
module amemory_16x1k
  import amemory_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int DEPTH_P  = DEPTH
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [DATA_W_P-1:0] DataIn_1,
  input  logic [DATA_W_P-1:0] DataIn_2,
  input  logic [ADDR_W_P-1:0] Address_1,
  input  logic [ADDR_W_P-1:0] Address_2,
  input  logic                WriteEna_1,
  input  logic                WriteEna_2,
  input  logic                ReadEna_1,
  input  logic                ReadEna_2,
  output logic [DATA_W_P-1:0] DataOut_1,
  output logic [DATA_W_P-1:0] DataOut_2
);

  localparam int IdxW = $clog2(DEPTH_P);

  // Power-up contents are all zero; reset deliberately leaves the array alone.
  logic [DATA_W_P-1:0] mem [DEPTH_P] = '{default: '0};

  logic [IdxW-1:0]     index1;
  logic [IdxW-1:0]     index2;
  logic [DATA_W_P-1:0] rdWord1;
  logic [DATA_W_P-1:0] rdWord2;

  // Combinational read of the pre-edge contents gives read-first behaviour on both ports.
  assign rdWord1 = mem[index1];
  assign rdWord2 = mem[index2];

  amemory_port #(
    .DATA_W_P(DATA_W_P),
    .ADDR_W_P(ADDR_W_P),
    .IDX_W_P (IdxW)
  ) port1 (
    .clk    (CLK),
    .reset  (Reset),
    .address(Address_1),
    .readEna(ReadEna_1),
    .rdWord (rdWord1),
    .index  (index1),
    .dataOut(DataOut_1)
  );

  amemory_port #(
    .DATA_W_P(DATA_W_P),
    .ADDR_W_P(ADDR_W_P),
    .IDX_W_P (IdxW)
  ) port2 (
    .clk    (CLK),
    .reset  (Reset),
    .address(Address_2),
    .readEna(ReadEna_2),
    .rdWord (rdWord2),
    .index  (index2),
    .dataOut(DataOut_2)
  );

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (WriteEna_2) mem[index2] <= DataIn_2;
      if (WriteEna_1) mem[index1] <= DataIn_1;
    end
  end

endmodule

// File: tb/tb_amemory_16x1k.sv
// Randomized + directed scoreboard bench for amemory_16x1k against an array-based reference.
module tb_amemory_16x1k;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] DataIn_1, DataIn_2, Address_1, Address_2;
  logic        WriteEna_1, WriteEna_2, ReadEna_1, ReadEna_2;
  logic [15:0] DataOut_1, DataOut_2;

  amemory_16x1k dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .DataIn_1  (DataIn_1),
    .DataIn_2  (DataIn_2),
    .Address_1 (Address_1),
    .Address_2 (Address_2),
    .WriteEna_1(WriteEna_1),
    .WriteEna_2(WriteEna_2),
    .ReadEna_1 (ReadEna_1),
    .ReadEna_2 (ReadEna_2),
    .DataOut_1 (DataOut_1),
    .DataOut_2 (DataOut_2)
  );

  always #5 CLK = ~CLK;

  logic [15:0] refMem [1024];
  logic [15:0] refOut1 = 16'h0;
  logic [15:0] refOut2 = 16'h0;
  logic [15:0] expQ1 [$];
  logic [15:0] expQ2 [$];
  int compared = 0;
  int mismatched = 0;
  bit monitorOn = 1'b1;

  // Drive one cycle of inputs and push the outputs the reference expects after that edge.
  task automatic step(input bit rst, input bit we1, input bit we2, input bit re1, input bit re2,
                      input logic [15:0] a1, input logic [15:0] a2,
                      input logic [15:0] d1, input logic [15:0] d2);
    int w1, w2;
    logic [15:0] old1, old2;
    @(negedge CLK);
    Reset = rst; WriteEna_1 = we1; WriteEna_2 = we2; ReadEna_1 = re1; ReadEna_2 = re2;
    Address_1 = a1; Address_2 = a2; DataIn_1 = d1; DataIn_2 = d2;
    w1 = int'(a1) % 1024;
    w2 = int'(a2) % 1024;
    if (rst) begin
      refOut1 = 16'h0;
      refOut2 = 16'h0;
    end else begin
      old1 = refMem[w1];
      old2 = refMem[w2];
      if (re1) refOut1 = old1;
      if (re2) refOut2 = old2;
      if (we1) refMem[w1] = d1;
      if (we2 && !(we1 && w1 == w2)) refMem[w2] = d2;
    end
    expQ1.push_back(refOut1);
    expQ2.push_back(refOut2);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  // Monitor: outputs are presented every cycle, compare one expectation per port per edge.
  initial begin
    logic [15:0] e;
    while (monitorOn) begin
      @(posedge CLK);
      #1;
      if (expQ1.size() > 0) begin
        e = expQ1.pop_front();
        compared++;
        if (DataOut_1 !== e) begin
          mismatched++;
          $display("FAIL DataOut_1 t=%0t got %h expected %h", $time, DataOut_1, e);
        end
      end
      if (expQ2.size() > 0) begin
        e = expQ2.pop_front();
        compared++;
        if (DataOut_2 !== e) begin
          mismatched++;
          $display("FAIL DataOut_2 t=%0t got %h expected %h", $time, DataOut_2, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] a1, a2, d1, d2, hi;
    for (int i = 0; i < 1024; i++) refMem[i] = 16'h0;
    Reset = 1'b1; WriteEna_1 = 1'b0; WriteEna_2 = 1'b0; ReadEna_1 = 1'b0; ReadEna_2 = 1'b0;
    Address_1 = '0; Address_2 = '0; DataIn_1 = '0; DataIn_2 = '0;

    // Reset state, then power-up contents read as zero
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0123, 16'h03FF, 16'h0, 16'h0);

    // Nonzero reads, reset for two cycles with writes requested, then readback survives
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, 16'h5A5A, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0006, 16'hDEAD, 16'hBEEF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0006, 16'hDEAD, 16'hBEEF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0006, 16'h0, 16'h0);

    // Port 1 writes data=address for 0..499, then reads them back
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 16'h0, 16'(i), 16'h0);
    for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(i), 16'h0, 16'h0, 16'h0);

    // Cross-port visibility and address aliasing
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0010, 16'h0, 16'hA5A5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0410, 16'h0, 16'h1234, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0010, 16'h0, 16'h0);

    // Same-address write collision
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0020, 16'h1111, 16'h2222);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h8020, 16'h0, 16'h0);

    // Port 1 write with port 2 read of the same word on the same edge
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h0030, 16'hBEEF, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0030, 16'h0, 16'h0);

    // Same-port read-first
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0031, 16'h0, 16'hCAFE, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0031, 16'h0, 16'h0, 16'h0);

    // Read enable low while addresses wander: outputs hold
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(i * 37), 16'(i * 53), 16'h0, 16'h0);

    // Randomized traffic, biased onto a small index window to force collisions
    for (int i = 0; i < 3000; i++) begin
      hi = 16'($urandom_range(0, 63)) << 10;
      a1 = ($urandom_range(0, 1) == 0) ? (hi | 16'($urandom_range(0, 7))) : 16'($urandom);
      hi = 16'($urandom_range(0, 63)) << 10;
      a2 = ($urandom_range(0, 1) == 0) ? (hi | 16'($urandom_range(0, 7))) : 16'($urandom);
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, a1, a2, d1, d2);
    end

    idle();
    idle();
    monitorOn = 1'b0;
    @(posedge CLK);
    #2;
    if (expQ1.size() != 0 || expQ2.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain left %0d/%0d expected 0/0", expQ1.size(), expQ2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/amemory_16x1k.md
AMEMORY_16X1K -- requirements
Module: amemory_16x1k

Interface
REQ-001 Parameter DATA_W, 16, data word width in bits.
REQ-002 Parameter ADDR_W, 16, address port width in bits.
REQ-003 Parameter DEPTH, 1024, number of storage words.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-006 DataIn_1  input  16  port-1 write data.
REQ-007 DataIn_2  input  16  port-2 write data.
REQ-008 Address_1  input  16  port-1 word address.
REQ-009 Address_2  input  16  port-2 word address.
REQ-010 WriteEna_1  input  1  port-1 write enable, active-high.
REQ-011 WriteEna_2  input  1  port-2 write enable, active-high.
REQ-012 ReadEna_1  input  1  port-1 read enable, active-high.
REQ-013 ReadEna_2  input  1  port-2 read enable, active-high.
REQ-014 DataOut_1  output  16  port-1 registered read data.
REQ-015 DataOut_2  output  16  port-2 registered read data.

Function
REQ-016 Storage SHALL be 1024 words x 16 bits, shared by both ports; each port SHALL be fully independent (true dual-port).
REQ-017 Each port SHALL use only address bits [9:0]; bits [15:10] are ignored, so address 0x0400 aliases 0x0000 (wrap).
REQ-018 On a rising edge with WriteEna_n=1 and Reset=0, the word at Address_n SHALL be replaced by DataIn_n.
REQ-019 On a rising edge with ReadEna_n=1 and Reset=0, DataOut_n SHALL load the word at Address_n; read latency is exactly one clock.
REQ-020 With ReadEna_n=0, DataOut_n SHALL hold its previous value.
REQ-021 Read and write on the same port and same edge SHALL be read-first: DataOut_n gets the old word, the new word is visible from the next read.
REQ-022 Cross-port read of an address written by the other port on the same edge SHALL return the old word.
REQ-023 Both ports writing the same address on the same edge: port 1 SHALL win; port 2's data is discarded.
REQ-024 Both ports reading any addresses (including the same one) on the same edge SHALL both return correct data.
REQ-025 No handshake; every enable is acted on in the cycle it is sampled, with no stall or busy state.

Reset
REQ-026 While Reset=1 at a rising edge, DataOut_1 and DataOut_2 SHALL become 0x0000 and no write SHALL occur.
REQ-027 Reset SHALL NOT clear memory contents; contents SHALL be 0x0000 at simulation start and otherwise preserved across reset.
REQ-028 The first edge after Reset deasserts SHALL process enables normally.

Structure
REQ-029 A shared package amemory_pkg SHALL hold DATA_W, ADDR_W, DEPTH and the derived index width (10).
REQ-030 One sub-module, amemory_port, SHALL implement per-port address truncation and the output register with read enable and reset; it is instantiated twice around a single shared array.

Verification
REQ-031 Reset=1 for 2 cycles after nonzero reads -> DataOut_1=DataOut_2=0x0000; a previously written word still reads back afterwards.
REQ-032 Port 1 writes data=address for addresses 0..499, then port 1 reads 0..499 -> each DataOut_1 equals its address one cycle after the read edge.
REQ-033 Port 2 writes 0xA5A5 to 0x0010, port 1 reads 0x0010 next cycle -> DataOut_1=0xA5A5; port-1 write of 0x1234 to 0x0410 -> port-2 read of 0x0010 returns 0x1234 (alias).
REQ-034 Same edge: port 1 writes 0x1111, port 2 writes 0x2222, both to 0x0020 -> subsequent read gives 0x1111.
REQ-035 Same edge: port 1 writes 0xBEEF to 0x0030 (old 0x0030) while port 2 reads 0x0030 -> DataOut_2=0x0030; next read -> 0xBEEF.
REQ-036 ReadEna_1=0 while Address_1 changes -> DataOut_1 holds its last value.
